// File: rtl/if_stream_fetch.sv
// if_stream_fetch: reads a contiguous block of words from the input-feature
// SRAM and replays them in order on a valid/ready stream. Reads are only
// issued when the small output FIFO has room for them, counting a read
// already in flight, so SRAM data never needs to be dropped or stalled.
// The SRAM read enable and address are registered. The issue decision for
// the next cycle is therefore made one cycle early, from next-state values.

module if_stream_fetch #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int LEN_W  = 19,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] RAM_IF_Q,
  output logic              RAM_IF_OE,
  output logic              RAM_IF_WE,
  output logic [ADDR_W-1:0] RAM_IF_A,
  output logic [DATA_W-1:0] RAM_IF_D,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_issued;
  logic [LEN_W-1:0]    r_emitted;
  logic                r_oe;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_done;
  logic                r_busy;
  logic                r_valid;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  state_t              w_state_nxt;
  logic                w_start_ok;
  logic                w_zero_start;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [LEN_W-1:0]    w_issued_nxt;
  logic [LEN_W-1:0]    w_emitted_nxt;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [ADDR_W-1:0]   w_base_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_issue_nxt;

  // Counters and FIFO occupancy as they will be after this edge
  always_comb begin
    w_push        = r_inflight;
    w_pop         = r_valid & out_ready;
    w_count_nxt   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_issued_nxt  = w_start_ok ? {LEN_W{1'b0}} : (r_issued + LEN_W'(r_oe));
    w_emitted_nxt = w_start_ok ? {LEN_W{1'b0}} : (r_emitted + LEN_W'(w_pop));
    w_len_nxt     = w_start_ok ? length : r_len;
    w_base_nxt    = w_start_ok ? base_addr : r_base;
    w_addr_nxt    = w_base_nxt + w_issued_nxt[ADDR_W-1:0];
    // the read issued this cycle becomes next cycle's in-flight read
    w_issue_nxt   = (w_state_nxt == S_FETCH) && (w_issued_nxt < w_len_nxt) &&
                    ((w_count_nxt + CNT_W'(r_oe)) < DEPTH_C);
  end

  // Transfer sequencing: next state and start qualification
  always_comb begin
    w_state_nxt  = r_state;
    w_start_ok   = 1'b0;
    w_zero_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length != {LEN_W{1'b0}}) begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_zero_start = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (r_oe && ((r_issued + LEN_W'(1)) == r_len)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        // leave on the edge of the last handshake so done follows it directly
        if (w_emitted_nxt == r_len) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state, counters and registered SRAM/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= {ADDR_W{1'b0}};
      r_len      <= {LEN_W{1'b0}};
      r_issued   <= {LEN_W{1'b0}};
      r_emitted  <= {LEN_W{1'b0}};
      r_oe       <= 1'b0;
      r_inflight <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_base     <= w_base_nxt;
      r_len      <= w_len_nxt;
      r_issued   <= w_issued_nxt;
      r_emitted  <= w_emitted_nxt;
      r_oe       <= w_issue_nxt;
      r_inflight <= r_oe;
      r_addr     <= w_issue_nxt ? w_addr_nxt : r_addr;
      r_done     <= (w_state_nxt == S_DONE) | w_zero_start;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Output FIFO: push returning SRAM data, pop on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= RAM_IF_Q;
      end
      r_wptr  <= r_wptr + PTR_W'(w_push);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != {CNT_W{1'b0}});
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign RAM_IF_OE = r_oe;
  assign RAM_IF_A  = r_addr;
  assign RAM_IF_WE = 1'b0;
  assign RAM_IF_D  = {DATA_W{1'b0}};
  assign out_valid = r_valid;
  assign out_data  = r_mem[r_rptr];

  if_stream_fetch_chk #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_count (r_count)
  );

endmodule

// Checker: the credit scheme must never let a returning word hit a full FIFO.
module if_stream_fetch_chk #(
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             i_push,
  input logic [CNT_W-1:0] i_count
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && (i_count == CNT_W'(DEPTH))));
endmodule

// File: tb/tb_if_stream_fetch.sv
// Bench for if_stream_fetch: SRAM model, reference queues of expected
// addresses and words, a cycle monitor and directed plus random transfers.

module tb_if_stream_fetch;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 24;
  localparam int LEN_W  = 19;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done;
  logic [DATA_W-1:0] RAM_IF_Q = '0;
  logic              RAM_IF_OE, RAM_IF_WE;
  logic [ADDR_W-1:0] RAM_IF_A;
  logic [DATA_W-1:0] RAM_IF_D;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] salt = '0;

  if_stream_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .RAM_IF_Q(RAM_IF_Q), .RAM_IF_OE(RAM_IF_OE),
    .RAM_IF_WE(RAM_IF_WE), .RAM_IF_A(RAM_IF_A), .RAM_IF_D(RAM_IF_D),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return ({6'b0, a} * 24'd3) + salt;
  endfunction

  // SRAM: one-cycle read latency, garbage when not enabled
  always @(posedge clk) begin
    RAM_IF_Q <= RAM_IF_OE ? ram_word(RAM_IF_A) : DATA_W'($urandom);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int oe_count, hs_count, done_count, outstanding, cyc, hs_first, hs_last;
  bit done_due, prev_stall, exp_done;
  logic [DATA_W-1:0] prev_data;

  // Cycle monitor, sampling mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_done = done_due;
      done_due = 1'b0;
      check_eq("we_tied", RAM_IF_WE, 0);
      check_eq("d_tied", RAM_IF_D, 0);
      check_eq("done", done, exp_done);
      if (done) done_count++;
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, prev_data);
      end
      if (RAM_IF_OE) begin
        oe_count++;
        outstanding++;
        if (addr_q.size() == 0) check_eq("oe_extra", 1, 0);
        else check_eq("rd_addr", RAM_IF_A, addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        hs_count++;
        outstanding--;
        if (hs_count == 1) hs_first = cyc;
        hs_last = cyc;
        if (exp_q.size() == 0) check_eq("extra_word", 1, 0);
        else begin
          check_eq("out_data", out_data, exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
      check_eq("credit", outstanding <= DEPTH, 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic clear_model();
    addr_q.delete();
    exp_q.delete();
    oe_count = 0; hs_count = 0; done_count = 0; outstanding = 0;
    done_due = 1'b0; prev_stall = 1'b0;
  endtask

  task automatic expect_block(input logic [ADDR_W-1:0] b, input int len);
    for (int i = 0; i < len; i++) begin
      logic [ADDR_W-1:0] a;
      a = b + ADDR_W'(i);
      addr_q.push_back(a);
      exp_q.push_back(ram_word(a));
    end
  endtask

  task automatic drive_ready(input int mode, input int k);
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ((k % 3) == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_oe"}, RAM_IF_OE, 0);
    check_eq({tag, "_addr"}, RAM_IF_A, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_data"}, out_data, 0);
  endtask

  task automatic run_xfer(input logic [ADDR_W-1:0] b, input int len, input int mode, input bit poke);
    bit finished;
    clear_model();
    expect_block(b, len);
    @(posedge clk); #1;
    drive_ready(mode, 0);
    start = 1'b1; base_addr = b; length = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0; base_addr = ADDR_W'($urandom); length = LEN_W'($urandom);
    check_eq("first_oe", RAM_IF_OE, 1);
    check_eq("busy_on", busy, 1);
    check_eq("valid_e0", out_valid, 0);
    drive_ready(mode, 1);
    @(posedge clk); #1;
    check_eq("valid_e1", out_valid, 0);
    drive_ready(mode, 2);
    @(posedge clk); #1;
    check_eq("valid_e2", out_valid, 1);
    if (poke) begin
      start = 1'b1; base_addr = ADDR_W'($urandom); length = LEN_W'(5);
    end
    finished = 1'b0;
    for (int k = 3; k < 600 && !finished; k++) begin
      drive_ready(mode, k);
      @(posedge clk); #1;
      start = 1'b0;
      finished = (done_count > 0);
    end
    check_eq("timeout", finished, 1);
    for (int k = 0; k < 6; k++) begin
      drive_ready(2, k);
      @(posedge clk); #1;
    end
    check_eq("oe_cycles", oe_count, len);
    check_eq("words", hs_count, len);
    check_eq("done_once", done_count, 1);
    check_eq("busy_off", busy, 0);
    if (mode == 0) check_eq("back2back", hs_last - hs_first, len - 1);
  endtask

  initial begin
    bit found;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    rst = 1'b0;

    // basic burst, RAM[i] = i*3
    salt = '0;
    run_xfer(18'h00010, 8, 0, 1'b0);

    // back-pressure, ready one cycle in three
    salt = DATA_W'($urandom);
    run_xfer(ADDR_W'($urandom), 16, 1, 1'b0);

    // address wrap
    run_xfer(18'h3FFFE, 4, 2, 1'b0);

    // zero length
    clear_model();
    @(posedge clk); #1;
    start = 1'b1; length = '0; base_addr = ADDR_W'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    done_due = 1'b1;
    check_eq("zl_busy", busy, 0);
    repeat (4) begin @(posedge clk); #1; end
    check_eq("zl_done_once", done_count, 1);
    check_eq("zl_no_oe", oe_count, 0);

    // start while busy is ignored
    run_xfer(ADDR_W'($urandom), 3, 0, 1'b1);

    // reset mid-transfer with a read in flight
    clear_model();
    expect_block(18'h01000, 10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 18'h01000; length = LEN_W'(10);
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk); #1;
      found = (oe_count >= 4);
    end
    check_eq("rst_wait", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    check_reset_vals("rst_mid");
    repeat (5) begin @(posedge clk); #1; end
    check_eq("rst_quiet_words", hs_count, 0);
    run_xfer(ADDR_W'($urandom), 2, 2, 1'b0);

    // random transfers
    for (int t = 0; t < 6; t++) begin
      salt = DATA_W'($urandom);
      run_xfer(ADDR_W'($urandom), $urandom_range(1, 20), $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
